load_store_unit: RTL and testbench

Data-memory access stage of the RV32I core, directly downstream of the ALU. Takes the ALU's computed load/store address and store data, runs a single request/acknowledge transaction on the data bus with correct byte lanes, and returns sign/zero-extended load data to writeback. Stalls the core through `busy` until the transaction completes or times out.

---
 rtl/load_store_unit.sv | 215 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I data-memory access stage: one request/acknowledge bus transaction per load/store.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] read_address,
    input  logic [31:0] write_address,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_adr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdat,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdat
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [31:0]   addr_r, addr_s;
    logic [2:0]    funct3_r, funct3_s;
    logic [31:0]   data_r, data_s;
    logic          we_r, we_s;
    logic          bus_req_s, bus_we_s, done_s, err_s;
    logic [31:0]   bus_adr_s, bus_wdat_s, load_data_s;
    logic [3:0]    bus_sel_s;
    logic          is_load_s, is_store_s, misalign_s;
    logic [31:0]   req_addr_s;

    function automatic logic access_bad(input logic is_st, input logic [2:0] f3, input logic mis);
        logic bad;
        case (f3)
            3'b000, 3'b001, 3'b010: bad = mis;
            3'b100, 3'b101:         bad = is_st;
            default:                bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_sel(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] sel;
        case (f3[1:0])
            2'b00:   sel = 4'b0001 << lo;
            2'b01:   sel = lo[1] ? 4'b1100 : 4'b0011;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] lane_wdat(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    assign is_load_s  = (opcode == OP_LOAD);
    assign is_store_s = (opcode == OP_STORE);
    assign req_addr_s = is_store_s ? write_address : read_address;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_s = ((funct3[1:0] == 2'b01) && req_addr_s[0]) ||
                        ((funct3[1:0] == 2'b10) && (req_addr_s[1:0] != 2'b00));
`else
    assign misalign_s = 1'b0;
`endif

    // Next-state, latch updates and next values of the registered outputs.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        addr_s      = addr_r;
        funct3_s    = funct3_r;
        data_s      = data_r;
        we_s        = we_r;
        bus_req_s   = 1'b0;
        bus_we_s    = 1'b0;
        bus_adr_s   = 32'h0;
        bus_sel_s   = 4'h0;
        bus_wdat_s  = 32'h0;
        done_s      = 1'b0;
        err_s       = 1'b0;
        load_data_s = 32'h0;
        busy        = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && (is_load_s || is_store_s)) begin
                    busy     = 1'b1;
                    addr_s   = req_addr_s;
                    funct3_s = funct3;
                    data_s   = store_data;
                    we_s     = is_store_s;
                    cnt_s    = '0;
                    if (access_bad(is_store_s, funct3, misalign_s)) begin
                        state_s = DONE;
                        done_s  = 1'b1;
                        err_s   = 1'b1;
                    end else begin
                        state_s    = REQ;
                        bus_req_s  = 1'b1;
                        bus_we_s   = is_store_s;
                        bus_adr_s  = {req_addr_s[31:2], 2'b00};
                        bus_sel_s  = lane_sel(funct3, req_addr_s[1:0]);
                        bus_wdat_s = lane_wdat(funct3, store_data);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                busy = 1'b1;
                if (bus_ack) begin
                    state_s     = DONE;
                    done_s      = 1'b1;
                    load_data_s = we_r ? 32'h0 : extend(funct3_r, addr_r[1:0], bus_rdat);
                end else if (cnt_r == CNT_LAST) begin
                    state_s = DONE;
                    done_s  = 1'b1;
                    err_s   = 1'b1;
                end else begin
                    cnt_s      = cnt_r + CW'(1);
                    bus_req_s  = 1'b1;
                    bus_we_s   = we_r;
                    bus_adr_s  = {addr_r[31:2], 2'b00};
                    bus_sel_s  = lane_sel(funct3_r, addr_r[1:0]);
                    bus_wdat_s = lane_wdat(funct3_r, data_r);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, transaction latches and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            addr_r    <= 32'h0;
            funct3_r  <= 3'b000;
            data_r    <= 32'h0;
            we_r      <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_adr   <= 32'h0;
            bus_sel   <= 4'h0;
            bus_wdat  <= 32'h0;
            done      <= 1'b0;
            err       <= 1'b0;
            load_data <= 32'h0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            addr_r    <= addr_s;
            funct3_r  <= funct3_s;
            data_r    <= data_s;
            we_r      <= we_s;
            bus_req   <= bus_req_s;
            bus_we    <= bus_we_s;
            bus_adr   <= bus_adr_s;
            bus_sel   <= bus_sel_s;
            bus_wdat  <= bus_wdat_s;
            done      <= done_s;
            err       <= err_s;
            load_data <= load_data_s;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table run through a scoreboard,
// plus hand sequences for late ack, non-memory opcodes and reset during a request.
module tb_load_store_unit;
    localparam int TMO = 4;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam int NEVER = 255;

    logic        clk = 1'b0;
    logic        nRst, start, busy, done, err, bus_req, bus_we, bus_ack;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] read_address, write_address, store_data, load_data;
    logic [31:0] bus_adr, bus_wdat, bus_rdat;
    logic [3:0]  bus_sel;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .nRst(nRst), .start(start), .opcode(opcode), .funct3(funct3),
        .read_address(read_address), .write_address(write_address), .store_data(store_data),
        .busy(busy), .done(done), .err(err), .load_data(load_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_adr(bus_adr), .bus_sel(bus_sel),
        .bus_wdat(bus_wdat), .bus_ack(bus_ack), .bus_rdat(bus_rdat)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] raddr;
        logic [31:0] waddr;
        logic [31:0] sdata;
        logic [31:0] rdat;
        int          wait_n;
        bit          bus;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic        we;
        logic [31:0] ld;
        logic        er;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [31:0] ld;
        logic        er;
        int          cyc;
    } exp_t;

    vec_t vec[13];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        int   waited = 0;
        int   req_cycles = 0;
        bit   seen_req = 1'b0;
        bit   got = 1'b0;
        @(negedge clk);
        start = 1'b1; opcode = v.op; funct3 = v.f3;
        read_address = v.raddr; write_address = v.waddr; store_data = v.sdata;
        sb.push_back('{v.ld, v.er, v.cyc});
        #1 check({tag, ".busy_issue"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            check({tag, ".busy"}, 32'(busy), 32'(!done));
            if (done) begin
                got = 1'b1;
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL %s.scoreboard: got done expected none pending", tag);
                end else begin
                    e = sb.pop_front();
                    check({tag, ".load_data"}, load_data, e.ld);
                    check({tag, ".err"}, 32'(err), 32'(e.er));
                    check({tag, ".done_cycle"}, 32'(c), 32'(e.cyc));
                end
            end else if (bus_req) begin
                req_cycles++;
                if (!seen_req) begin
                    seen_req = 1'b1;
                    check({tag, ".bus_adr"}, bus_adr, v.adr);
                    check({tag, ".bus_sel"}, 32'(bus_sel), 32'(v.sel));
                    check({tag, ".bus_we"}, 32'(bus_we), 32'(v.we));
                    if (v.we) check({tag, ".bus_wdat"}, bus_wdat, v.wdat);
                end
                if (waited == v.wait_n) begin
                    bus_ack = 1'b1;
                    bus_rdat = v.rdat;
                end else begin
                    waited++;
                end
            end
            @(posedge clk);
            #1 bus_ack = 1'b0; bus_rdat = 32'h0;
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL %s.timeout: got no done expected done within 40 cycles", tag);
            void'(sb.pop_front());
        end
        check({tag, ".bus_cycle"}, 32'(seen_req), 32'(v.bus));
        check({tag, ".req_cycles"}, 32'(req_cycles), v.bus ? 32'(v.cyc - 1) : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = '{LD, 3'b010, 32'h100, 32'hFFFF_FFF0, 32'h0, 32'hDEADBEEF, 3, 1'b1,
                    32'h100, 4'b1111, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 5};
        vec[1]  = '{LD, 3'b000, 32'h103, 32'hFFFF_FFF0, 32'h0, 32'h80FF1234, 0, 1'b1,
                    32'h100, 4'b1000, 32'h0, 1'b0, 32'hFFFFFF80, 1'b0, 2};
        vec[2]  = '{LD, 3'b100, 32'h103, 32'hFFFF_FFF0, 32'h0, 32'h80FF1234, 1, 1'b1,
                    32'h100, 4'b1000, 32'h0, 1'b0, 32'h00000080, 1'b0, 3};
        vec[3]  = '{ST, 3'b001, 32'hFFFF_FFF0, 32'h206, 32'h1234ABCD, 32'h55555555, 1, 1'b1,
                    32'h204, 4'b1100, 32'hABCDABCD, 1'b1, 32'h0, 1'b0, 3};
        vec[4]  = '{LD, 3'b001, 32'h102, 32'h0, 32'h0, 32'h80017FFF, 2, 1'b1,
                    32'h100, 4'b1100, 32'h0, 1'b0, 32'hFFFF8001, 1'b0, 4};
        vec[5]  = '{LD, 3'b101, 32'h100, 32'h0, 32'h0, 32'h8001F00D, 0, 1'b1,
                    32'h100, 4'b0011, 32'h0, 1'b0, 32'h0000F00D, 1'b0, 2};
        vec[6]  = '{ST, 3'b000, 32'h0, 32'h301, 32'h000000A5, 32'h0, 0, 1'b1,
                    32'h300, 4'b0010, 32'hA5A5A5A5, 1'b1, 32'h0, 1'b0, 2};
        vec[7]  = '{ST, 3'b010, 32'h0, 32'h400, 32'hCAFEF00D, 32'h0, 2, 1'b1,
                    32'h400, 4'b1111, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0, 4};
        vec[8]  = '{LD, 3'b011, 32'h100, 32'h0, 32'h0, 32'h0, 0, 1'b0,
                    32'h0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1, 1};
        vec[9]  = '{ST, 3'b100, 32'h0, 32'h100, 32'h12345678, 32'h0, 0, 1'b0,
                    32'h0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1, 1};
`ifdef LSU_MISALIGN_TRAP_EN
        vec[10] = '{LD, 3'b010, 32'h102, 32'h0, 32'h0, 32'h11223344, 0, 1'b0,
                    32'h0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1, 1};
`else
        vec[10] = '{LD, 3'b010, 32'h102, 32'h0, 32'h0, 32'h11223344, 0, 1'b1,
                    32'h100, 4'b1111, 32'h0, 1'b0, 32'h11223344, 1'b0, 2};
`endif
        vec[11] = '{LD, 3'b000, 32'h101, 32'h0, 32'h0, 32'h00007F00, 0, 1'b1,
                    32'h100, 4'b0010, 32'h0, 1'b0, 32'h0000007F, 1'b0, 2};
        vec[12] = '{LD, 3'b010, 32'h300, 32'h0, 32'h0, 32'h0, NEVER, 1'b1,
                    32'h300, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b1, TMO + 1};

        nRst = 1'b0; start = 1'b0; opcode = 7'h0; funct3 = 3'b000;
        read_address = 32'h0; write_address = 32'h0; store_data = 32'h0;
        bus_ack = 1'b0; bus_rdat = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.bus_req", 32'(bus_req), 32'd0);
        check("rst.bus_we", 32'(bus_we), 32'd0);
        check("rst.bus_adr", bus_adr, 32'h0);
        check("rst.bus_sel", 32'(bus_sel), 32'd0);
        check("rst.bus_wdat", bus_wdat, 32'h0);
        check("rst.done_err", {30'd0, done, err}, 32'd0);
        check("rst.load_data", load_data, 32'h0);
        check("rst.busy", 32'(busy), 32'd0);
        nRst = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vec[i], $sformatf("v%0d", i));

        // Ack arriving after the timeout has retired the access must be ignored.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_ack = 1'b1; bus_rdat = 32'hBADBAD00;
            check("late_ack.done", 32'(done), 32'd0);
            check("late_ack.bus_req", 32'(bus_req), 32'd0);
        end
        @(negedge clk);
        bus_ack = 1'b0;

        // Non-memory opcode leaves the unit idle.
        start = 1'b1; opcode = 7'b0110011; funct3 = 3'b010; read_address = 32'h100;
        #1 check("nonmem.busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("nonmem.bus_req", 32'(bus_req), 32'd0);
        check("nonmem.done", 32'(done), 32'd0);

        // Reset while a request is outstanding, then a stray ack.
        start = 1'b1; opcode = LD; funct3 = 3'b010; read_address = 32'h500;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("rstreq.bus_req_on", 32'(bus_req), 32'd1);
        @(negedge clk);
        nRst = 1'b0;
        @(posedge clk);
        #1 nRst = 1'b1; bus_ack = 1'b1; bus_rdat = 32'h01020304;
        @(negedge clk);
        check("rstreq.bus_req_off", 32'(bus_req), 32'd0);
        check("rstreq.busy", 32'(busy), 32'd0);
        check("rstreq.done0", 32'(done), 32'd0);
        @(posedge clk);
        #1 bus_ack = 1'b0; bus_rdat = 32'h0;
        @(negedge clk);
        check("rstreq.done1", 32'(done), 32'd0);
        check("rstreq.bus_req1", 32'(bus_req), 32'd0);

        run_vec(vec[0], "after_rst");

        check("scoreboard.empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
